// File: rtl/jtframe_ba_arb.sv
// Four-slot arbiter onto one SDRAM bank port: round-robin (or slot-0 priority),
// with a registered request/ack/rdy handshake and a sticky watchdog error flag.
module jtframe_ba_arb #(
    parameter int AW     = 22,
    parameter int FIXED0 = 0,
    parameter int TOUT   = 255
)(
    input  logic          clk,
    input  logic          rst,

    input  logic [AW-1:0] slot0_addr,
    input  logic [AW-1:0] slot1_addr,
    input  logic [AW-1:0] slot2_addr,
    input  logic [AW-1:0] slot3_addr,
    input  logic          slot0_rd,
    input  logic          slot1_rd,
    input  logic          slot2_rd,
    input  logic          slot3_rd,
    input  logic          slot0_wr,
    input  logic [15:0]   slot0_din,
    input  logic [1:0]    slot0_din_m,

    output logic          slot0_ok,
    output logic          slot1_ok,
    output logic          slot2_ok,
    output logic          slot3_ok,
    output logic [31:0]   slot_dout,

    output logic [AW-1:0] ba_addr,
    output logic          ba_rd,
    output logic          ba_wr,
    output logic [15:0]   ba_din,
    output logic [1:0]    ba_din_m,
    input  logic          ba_ack,
    input  logic          ba_rdy,
    input  logic [31:0]   ba_dout,

    output logic          err,
    output logic [1:0]    dbg_state
);

    // Bank handshake: ba_rd/ba_wr and their payload stay stable from grant until
    // ba_ack; ba_rdy then marks data valid (reads) or completion (writes).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t        state, nxt_state;
    logic [1:0]    cur, nxt_cur;
    logic [1:0]    last, nxt_last;
    logic          cur_wr, nxt_cur_wr;
    logic [3:0]    ok, nxt_ok;
    logic [9:0]    wdog, nxt_wdog;
    logic [AW-1:0] nxt_ba_addr;
    logic          nxt_ba_rd, nxt_ba_wr;
    logic [15:0]   nxt_ba_din;
    logic [1:0]    nxt_ba_din_m;
    logic [31:0]   nxt_slot_dout;
    logic          nxt_err;

    logic [AW-1:0] slot_addr [4];
    logic [3:0]    req, pend;
    logic          win_vld;
    logic [1:0]    win, cand;
    logic          tout_hit;

    assign slot_addr[0] = slot0_addr;
    assign slot_addr[1] = slot1_addr;
    assign slot_addr[2] = slot2_addr;
    assign slot_addr[3] = slot3_addr;

    // A slot whose ok is high this cycle has just been served and must not re-enter.
    assign req  = {slot3_rd, slot2_rd, slot1_rd, slot0_rd | slot0_wr};
    assign pend = req & ~ok;

    assign tout_hit = (wdog == 10'(TOUT - 1));

    assign slot0_ok  = ok[0];
    assign slot1_ok  = ok[1];
    assign slot2_ok  = ok[2];
    assign slot3_ok  = ok[3];
    assign dbg_state = state;

    // Scan from farthest to nearest so the slot right after 'last' wins.
    always_comb begin
        win_vld = 1'b0;
        win     = last;
        cand    = last;
        for (int k = 4; k >= 1; k--) begin
            cand = last + 2'(k);
            if (pend[cand]) begin
                win_vld = 1'b1;
                win     = cand;
            end
        end
        if (FIXED0 != 0 && pend[0]) begin
            win_vld = 1'b1;
            win     = 2'd0;
        end
    end

    always_comb begin
        nxt_state     = state;
        nxt_cur       = cur;
        nxt_last      = last;
        nxt_cur_wr    = cur_wr;
        nxt_ok        = 4'd0;
        nxt_wdog      = wdog;
        nxt_ba_addr   = ba_addr;
        nxt_ba_rd     = ba_rd;
        nxt_ba_wr     = ba_wr;
        nxt_ba_din    = ba_din;
        nxt_ba_din_m  = ba_din_m;
        nxt_slot_dout = slot_dout;
        nxt_err       = err;

        case (state)
            IDLE: begin
                if (win_vld) begin
                    nxt_state = REQ;
                    nxt_cur   = win;
                    nxt_last  = win;
                    nxt_wdog  = 10'd0;
                    if (win == 2'd0 && slot0_wr) begin
                        nxt_ba_wr    = 1'b1;
                        nxt_ba_addr  = slot0_addr;
                        nxt_ba_din   = slot0_din;
                        nxt_ba_din_m = slot0_din_m;
                        nxt_cur_wr   = 1'b1;
                    end else begin
                        // Reads are 32-bit bursts of two words, always even-aligned.
                        nxt_ba_rd    = 1'b1;
                        nxt_ba_addr  = slot_addr[win] & ~AW'(1);
                        nxt_ba_din_m = 2'b11;
                        nxt_cur_wr   = 1'b0;
                    end
                end
            end
            REQ: begin
                nxt_wdog = wdog + 10'd1;
                if (ba_ack && ba_rdy) begin
                    nxt_ba_rd   = 1'b0;
                    nxt_ba_wr   = 1'b0;
                    nxt_ok[cur] = 1'b1;
                    nxt_state   = IDLE;
                    if (!cur_wr) nxt_slot_dout = ba_dout;
                end else if (tout_hit) begin
                    nxt_ba_rd = 1'b0;
                    nxt_ba_wr = 1'b0;
                    nxt_err   = 1'b1;
                    nxt_state = IDLE;
                end else if (ba_ack) begin
                    nxt_ba_rd = 1'b0;
                    nxt_ba_wr = 1'b0;
                    nxt_state = WAIT;
                end
            end
            WAIT: begin
                nxt_wdog = wdog + 10'd1;
                if (ba_rdy) begin
                    nxt_ok[cur] = 1'b1;
                    nxt_state   = IDLE;
                    if (!cur_wr) nxt_slot_dout = ba_dout;
                end else if (tout_hit) begin
                    // Abandoned without ok; the client's held request is arbitrated again.
                    nxt_err   = 1'b1;
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur       <= 2'd0;
            last      <= 2'd3;
            cur_wr    <= 1'b0;
            ok        <= 4'd0;
            wdog      <= 10'd0;
            ba_addr   <= '0;
            ba_rd     <= 1'b0;
            ba_wr     <= 1'b0;
            ba_din    <= 16'd0;
            ba_din_m  <= 2'b11;
            slot_dout <= 32'd0;
            err       <= 1'b0;
        end else begin
            state     <= nxt_state;
            cur       <= nxt_cur;
            last      <= nxt_last;
            cur_wr    <= nxt_cur_wr;
            ok        <= nxt_ok;
            wdog      <= nxt_wdog;
            ba_addr   <= nxt_ba_addr;
            ba_rd     <= nxt_ba_rd;
            ba_wr     <= nxt_ba_wr;
            ba_din    <= nxt_ba_din;
            ba_din_m  <= nxt_ba_din_m;
            slot_dout <= nxt_slot_dout;
            err       <= nxt_err;
        end
    end

endmodule

// File: doc/jtframe_ba_arb.md
JTFRAME_BA_ARB -- requirements
Module: jtframe_ba_arb

Interface
REQ-001 SHALL have parameter AW, default 22: SDRAM word-address width.
REQ-002 SHALL have parameter FIXED0, default 0: 1 gives slot 0 absolute priority; 0 gives pure round-robin.
REQ-003 SHALL have parameter TOUT, default 255: watchdog limit in clk cycles, range 1..1023.
REQ-004 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports slot0..3_addr  in  AW  client word address.
REQ-007 SHALL have ports slot0..3_rd  in  1  read request; client holds it high until the matching ok.
REQ-008 SHALL have port slot0_wr  in  1  write request, slot 0 only; client holds it high until ok.
REQ-009 SHALL have ports slot0_din  in  16  and  slot0_din_m  in  2, giving write data and byte mask (1 = keep byte).
REQ-010 SHALL have ports slot0..3_ok  out  1  one-cycle completion pulse.
REQ-011 SHALL have port slot_dout  out  32  read data from the last completed read.
REQ-012 SHALL have ports ba_addr  out  AW,  ba_rd  out  1,  ba_wr  out  1,  ba_din  out  16,  ba_din_m  out  2, driving the shared bank port.
REQ-013 SHALL have ports ba_ack  in  1,  ba_rdy  in  1,  ba_dout  in  32, returned by the bank port.
REQ-014 SHALL have port err  out  1  sticky watchdog flag.

Function
REQ-015 SHALL implement an FSM with states IDLE, REQ and WAIT; all outputs SHALL be registered.
REQ-016 Pending slot: (rd, or wr for slot 0) is high and its ok is not high in the current cycle.
REQ-017 In IDLE with a pending slot, the winner SHALL be taken in search order last+1, last+2, last+3, last (mod 4); with FIXED0=1, a pending slot 0 SHALL always win.
REQ-018 On a grant the arbiter SHALL, at the next edge, load ba_addr, ba_rd or ba_wr, ba_din and ba_din_m, set cur and last to the winner, and enter REQ.
REQ-019 For reads, ba_addr[0] SHALL be forced to 0 (32-bit burst of 2); for writes, ba_addr SHALL carry the full address.
REQ-020 If slot 0 has both rd and wr high, the write SHALL take precedence.
REQ-021 In REQ, the ba_* outputs SHALL hold stable until ba_ack; on ba_ack, ba_rd and ba_wr SHALL clear at the same edge and the FSM SHALL enter WAIT.
REQ-022 In WAIT, on ba_rdy: slot_dout SHALL load ba_dout for reads and stay unchanged for writes; slotcur_ok SHALL pulse for exactly one cycle; the FSM SHALL return to IDLE.
REQ-023 If ba_ack and ba_rdy arrive in the same REQ cycle, the arbiter SHALL complete directly (REQ-022 actions) and skip WAIT.
REQ-024 The minimum gap between two grants SHALL be 1 IDLE cycle; back-to-back requests from the same slot SHALL not be double-serviced.
REQ-025 A request SHALL not be granted while any slot's ok is high for that slot.
REQ-026 A watchdog counter SHALL clear on grant and increment in REQ and WAIT.
REQ-027 When the watchdog reaches TOUT: err SHALL set, ba_rd and ba_wr SHALL clear, no ok SHALL be issued, and the FSM SHALL return to IDLE; the held client request SHALL then be re-arbitrated normally.
REQ-028 A client that drops its request after grant SHALL not abort the transaction; ok SHALL still pulse.

Reset
REQ-029 While rst=1 at an edge: FSM SHALL be IDLE; ba_rd, ba_wr, all ok and err SHALL be 0; ba_addr, ba_din, slot_dout and the watchdog SHALL be 0; ba_din_m SHALL be 2'b11; last SHALL be 3.
REQ-030 rst asserted mid-transaction SHALL abandon it with no ok pulse; the first grant after reset SHALL follow REQ-017 from last=3.

Verification
REQ-031 Slot 2 reads address 0x000105 from reset → ba_addr=0x000104, ba_rd=1 one cycle after the request; after ack and rdy with ba_dout=0xDEADBEEF → slot_dout=0xDEADBEEF and slot2_ok high for exactly 1 cycle.
REQ-032 All four slots read continuously with FIXED0=0 → grant order 0,1,2,3,0,… and no slot starves.
REQ-033 FIXED0=1 with slots 0 and 3 both continuous → slot 0 wins every IDLE cycle in which it is pending.
REQ-034 Slot 0 writes 0x1234 with din_m=2'b01 at address 0x3 → ba_wr=1, ba_addr=0x3, ba_din_m=2'b01; slot_dout unchanged; slot0_ok pulses once.
REQ-035 Bank model never asserts ba_rdy, TOUT=16 → ba_rd drops and err=1 at cycle 16 after grant with no ok; the request is re-granted in the next IDLE cycle.
REQ-036 ba_ack and ba_rdy in the same cycle → ok one cycle later, WAIT never entered; rst pulsed during WAIT → no ok and all outputs at reset values.
